// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the bit-serial subtractor.
// Contents: FSM state enum, default operand width, bit-counter width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 16;

    // Counter only needs to reach width-1, so $clog2(width) bits suffice.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: combinational one-bit subtractor cell computing a - b - br.
// Ports: a_i minuend bit, b_i subtrahend bit, br_i borrow in,
//        diff_o difference bit, borrow_o borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic diff_o,
    output logic borrow_o
);

    assign diff_o   = a_i ^ b_i ^ br_i;
    assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement a - b, LSB first, one bit per clock.
// Ports: clk_i/rst_n_i clock and async active-low reset;
//        in_valid_i/in_ready_o/a_i/b_i operand handshake;
//        out_valid_o/out_ready_i/diff_o result handshake;
//        borrow_o unsigned borrow, zr_o zero, ng_o negative, ovf_o signed overflow.
module serial_subtractor
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             zr_o,
    output logic             ng_o,
    output logic             ovf_o
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             borrow_q, borrow_d, zr_q, zr_d, ng_q, ng_d, ovf_q, ovf_d;
    logic             bit_d, bit_br;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .br_i     (br_q),
        .diff_o   (bit_d),
        .borrow_o (bit_br)
    );

    // Result fills from the top so after WIDTH shifts bit 0 sits at index 0.
    assign res_next = {bit_d, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zr_d     = zr_q;
        ng_d     = ng_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                state_d = RUN;
                a_d     = a_i;
                b_d     = b_i;
                br_d    = 1'b0;
                cnt_d   = '0;
                a_msb_d = a_i[WIDTH-1];
                b_msb_d = b_i[WIDTH-1];
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_next;
                br_d  = bit_br;
                cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    diff_d   = res_next;
                    borrow_d = bit_br;
                    zr_d     = (res_next == '0);
                    ng_d     = res_next[WIDTH-1];
                    // Overflow only possible when operand signs differ.
                    ovf_d    = (a_msb_q != b_msb_q) & (res_next[WIDTH-1] != a_msb_q);
                end
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zr_q     <= zr_d;
            ng_q     <= ng_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;
    assign zr_o        = zr_q;
    assign ng_o        = ng_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         zr_o;
    logic         ng_o;
    logic         ovf_o;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .diff_o      (diff_o),
        .borrow_o    (borrow_o),
        .zr_o        (zr_o),
        .ng_o        (ng_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain modular/integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic br, output logic zr,
                         output logic ng, output logic ov);
        longint sa, sb, sd, lim;
        d   = a - b;
        br  = (a < b);
        zr  = (d == '0);
        ng  = d[W-1];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sd  = sa - sb;
        lim = longint'(1) << (W - 1);
        ov  = (sd > lim - 1) || (sd < -lim);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, input bit scramble);
        logic [W-1:0] ed;
        logic eb, ez, en, eo;
        model(a, b, ed, eb, ez, en, eo);
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_idle: got %b want 1", in_ready_o);
        end
        in_valid_i = 1'b1;
        a_i = a;
        b_i = b;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (scramble) begin
                in_valid_i = 1'($urandom);
                a_i = W'($urandom);
                b_i = W'($urandom);
            end
            @(posedge clk_i);
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== (k == W)) begin
                errors++;
                $display("FAIL latency: edge T+%0d out_valid=%b want %b", k, out_valid_o, (k == W));
            end
            checks++;
            if (in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_busy: edge T+%0d got %b want 0", k, in_ready_o);
            end
        end
        in_valid_i = 1'b0;
        checks++;
        if ({diff_o, borrow_o, zr_o, ng_o, ovf_o} !== {ed, eb, ez, en, eo}) begin
            errors++;
            $display("FAIL result a=%h b=%h: got diff=%h br=%b zr=%b ng=%b ov=%b want diff=%h br=%b zr=%b ng=%b ov=%b",
                     a, b, diff_o, borrow_o, zr_o, ng_o, ovf_o, ed, eb, ez, en, eo);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            checks++;
            if ({out_valid_o, in_ready_o, diff_o} !== {1'b1, 1'b0, ed}) begin
                errors++;
                $display("FAIL hold: cycle %0d valid=%b ready=%b diff=%h want 1 0 %h",
                         s, out_valid_o, in_ready_o, diff_o, ed);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        checks++;
        if ({out_valid_o, in_ready_o, diff_o} !== {1'b0, 1'b1, ed}) begin
            errors++;
            $display("FAIL handoff: valid=%b ready=%b diff=%h want 0 1 %h",
                     out_valid_o, in_ready_o, diff_o, ed);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        a_i = '0;
        b_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({in_ready_o, out_valid_o, diff_o, borrow_o, zr_o, ng_o, ovf_o} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0}) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b diff=%h flags=%b%b%b%b",
                     in_ready_o, out_valid_o, diff_o, borrow_o, zr_o, ng_o, ovf_o);
        end
        rst_n_i = 1'b1;
    endtask

    task automatic test_directed();
        do_op(16'd5, 16'd3, 0, 1'b0);
        do_op(16'd3, 16'd5, 0, 1'b0);
        do_op(16'h8000, 16'h0001, 1, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 0, 1'b0);
        do_op(16'h0000, 16'h8000, 0, 1'b0);
        do_op(16'hFFFF, 16'h0000, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(16'h1234, 16'h1234, 10, 1'b0);
    endtask

    task automatic test_ignore_inputs();
        do_op(16'hA5A5, 16'h1357, 2, 1'b1);
        do_op(16'h0042, 16'hC000, 0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk_i);
        in_valid_i = 1'b1;
        a_i = 16'hFFFF;
        b_i = 16'h0001;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (7) @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        checks++;
        if ({in_ready_o, out_valid_o, diff_o, borrow_o, zr_o, ng_o, ovf_o} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0}) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b diff=%h flags=%b%b%b%b",
                     in_ready_o, out_valid_o, diff_o, borrow_o, zr_o, ng_o, ovf_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            checks++;
            if ({out_valid_o, in_ready_o} !== 2'b01) begin
                errors++;
                $display("FAIL post_reset: cycle %0d valid=%b ready=%b want 0 1", k, out_valid_o, in_ready_o);
            end
        end
        do_op(16'h0100, 16'h0001, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ed;
        logic eb, ez, en, eo;
        int last = -1;
        int seen = 0;
        model(16'h4321, 16'h1111, ed, eb, ez, en, eo);
        @(negedge clk_i);
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        a_i = 16'h4321;
        b_i = 16'h1111;
        for (int c = 0; c < 3 * (W + 2) + 2; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (out_valid_o === 1'b1) begin
                seen++;
                checks++;
                if (diff_o !== ed) begin
                    errors++;
                    $display("FAIL b2b_diff: got %h want %h", diff_o, ed);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last !== W + 2) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d want %0d", c - last, W + 2);
                    end
                end
                last = c;
            end
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        checks++;
        if (seen < 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want at least 3", seen);
        end
        repeat (W + 3) @(posedge clk_i);
        @(negedge clk_i);
        if (out_valid_o === 1'b1) begin
            out_ready_i = 1'b1;
            @(negedge clk_i);
            out_ready_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_inputs();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
